// File: rtl/fxp_pkg.sv
// Shared definitions for the 20-bit sign-magnitude fixed-point datapath.
// Word layout: sign at the MSB, INT_BITS integer bits, FRAC_BITS fraction bits.
package fxp_pkg;

    localparam int BITSIZE   = 20;
    localparam int FRAC_BITS = 15;
    localparam int INT_BITS  = BITSIZE - 1 - FRAC_BITS;
    localparam int MAG_W     = BITSIZE - 1;
    localparam int PROD_W    = 2 * MAG_W;

    localparam logic [MAG_W-1:0] MAG_MAX = {MAG_W{1'b1}};

    typedef logic [BITSIZE-1:0] fxp_t;
    typedef logic [MAG_W-1:0]   mag_t;
    typedef logic [PROD_W-1:0]  prod_t;

endpackage

// File: rtl/fxp_sat_trunc.sv
// Turns a full-width unsigned magnitude product plus a sign into a fixed-point word:
// drops the extra fraction bits (toward zero), saturates, and never emits negative zero.
module fxp_sat_trunc
    import fxp_pkg::*;
(
    input  prod_t product,
    input  logic  sign,
    output fxp_t  word,
    output logic  overflow
);

    prod_t shifted_s;
    mag_t  mag_s;
    logic  ovf_s;

    // Truncate, clamp to full scale, and clear the sign on a zero magnitude.
    always_comb begin
        shifted_s = product >> FRAC_BITS;
        ovf_s     = (shifted_s > PROD_W'(MAG_MAX));
        if (ovf_s) begin
            mag_s = MAG_MAX;
        end else begin
            mag_s = shifted_s[MAG_W-1:0];
        end
        if (mag_s == {MAG_W{1'b0}}) begin
            word = {BITSIZE{1'b0}};
        end else begin
            word = {sign, mag_s};
        end
        overflow = ovf_s;
    end

endmodule

// File: rtl/fixed_point_multiply.sv
// Registered sign-magnitude fixed-point multiplier, one result per cycle, latency one.
// C and overflow keep their last value while no new operand pair is presented.
module fixed_point_multiply
    import fxp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  fxp_t A,
    input  fxp_t B,
    output fxp_t C,
    output logic out_valid,
    output logic overflow
);

    prod_t product_s;
    logic  sign_s;
    fxp_t  word_s;
    logic  ovf_s;

    fxp_t  c_r;
    logic  out_valid_r;
    logic  overflow_r;

    // Magnitudes multiply unsigned; the sign is handled separately.
    assign product_s = PROD_W'(A[MAG_W-1:0]) * PROD_W'(B[MAG_W-1:0]);
    assign sign_s    = A[BITSIZE-1] ^ B[BITSIZE-1];

    fxp_sat_trunc u_sat_trunc (
        .product  (product_s),
        .sign     (sign_s),
        .word     (word_s),
        .overflow (ovf_s)
    );

    // Output register: capture on in_valid, otherwise hold data and drop valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_r         <= {BITSIZE{1'b0}};
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else if (in_valid) begin
            c_r         <= word_s;
            out_valid_r <= 1'b1;
            overflow_r  <= ovf_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign C         = c_r;
    assign out_valid = out_valid_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_fixed_point_multiply.sv
// Scoreboard bench for fixed_point_multiply: the driver queues hand-computed results,
// a monitor pops and compares them whenever out_valid is seen, including the cycle it appears.
module tb_fixed_point_multiply;

    typedef struct {
        logic [19:0] c;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [19:0] a_s;
    logic [19:0] b_s;
    logic [19:0] c_s;
    logic        out_valid_s;
    logic        overflow_s;

    exp_t        sb_q[$];
    int          checks;
    int          errors;
    int          cyc;

    fixed_point_multiply dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (a_s),
        .B         (b_s),
        .C         (c_s),
        .out_valid (out_valid_s),
        .overflow  (overflow_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Directed vectors: A, B, expected C, expected overflow.
    localparam int NV = 15;
    logic [19:0] va [NV] = '{20'h02000, 20'h40000, 20'h82000, 20'h80001, 20'h80001,
                             20'h80001, 20'h7FFFF, 20'hFFFFF, 20'h40000, 20'hC0000,
                             20'h08000, 20'h88000, 20'h00000, 20'h80000, 20'h0C000};
    logic [19:0] vb [NV] = '{20'h02000, 20'h02000, 20'h40000, 20'h08000, 20'h40000,
                             20'h02000, 20'h10000, 20'h40000, 20'hC0000, 20'hC0000,
                             20'h08000, 20'h0C000, 20'h7FFFF, 20'h85555, 20'h8C000};
    logic [19:0] vc [NV] = '{20'h00800, 20'h10000, 20'h90000, 20'h80001, 20'h80008,
                             20'h00000, 20'h7FFFF, 20'hFFFFF, 20'hFFFFF, 20'h7FFFF,
                             20'h08000, 20'h8C000, 20'h00000, 20'h00000, 20'h92000};
    logic        vo [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic issue(input logic [19:0] a, input logic [19:0] b,
                         input logic [19:0] ec, input logic eo);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        a_s      = a;
        b_s      = b;
        e.c      = ec;
        e.ovf    = eo;
        e.due    = cyc + 1;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        a_s      = 20'h12345;
        b_s      = 20'h54321;
    endtask

    // Monitor: every valid output must match the oldest queued expectation on its due cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && out_valid_s === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid_s), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("result_C", 32'(c_s), 32'(e.c));
                check("result_overflow", 32'(overflow_s), 32'(e.ovf));
                check("result_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b1;
        a_s      = 20'h7FFFF;
        b_s      = 20'h7FFFF;

        // Reset dominates an active in_valid.
        repeat (2) @(posedge clk);
        #1;
        check("reset_C", 32'(c_s), 32'd0);
        check("reset_out_valid", 32'(out_valid_s), 32'd0);
        check("reset_overflow", 32'(overflow_s), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        // Throughput: four distinct pairs back to back, then idle.
        for (int i = 0; i < 4; i++) issue(va[i], vb[i], vc[i], vo[i]);
        idle();
        @(posedge clk);
        #2;
        check("idle_out_valid", 32'(out_valid_s), 32'd0);
        check("idle_C_held", 32'(c_s), 32'(vc[3]));

        // Remaining vectors, all back to back.
        for (int i = 4; i < NV; i++) issue(va[i], vb[i], vc[i], vo[i]);
        idle();
        @(posedge clk);
        #2;
        check("final_out_valid", 32'(out_valid_s), 32'd0);
        check("final_C_held", 32'(c_s), 32'(vc[NV-1]));

        // A saturated result followed by idle keeps overflow high.
        issue(20'hC0000, 20'hC0000, 20'h7FFFF, 1'b1);
        idle();
        repeat (2) @(posedge clk);
        #2;
        check("hold_overflow", 32'(overflow_s), 32'd1);
        check("hold_C_sat", 32'(c_s), 32'h7FFFF);

        // Reset mid-stream clears everything.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("reset2_C", 32'(c_s), 32'd0);
        check("reset2_overflow", 32'(overflow_s), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before limit");
        $fatal(1);
    end

endmodule
